// File: rtl/goertzel_sched_if.sv
// Sample, multiplier and result streams of the Goertzel scheduler.
// The scheduler side uses the master modport and the environment uses the slave modport.
interface goertzel_sched_if #(
    parameter int NF = 11
);
    localparam int BW = $clog2(NF);

    logic signed [63:0] x_i;
    logic               x_valid;
    logic               x_ready;
    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic signed [63:0] mul_c;
    logic               res_valid;
    logic               res_ready;
    logic [BW-1:0]      res_bin;
    logic signed [63:0] res_s1;
    logic signed [63:0] res_s2;

    modport master (
        input  x_i, x_valid, mul_c, res_ready,
        output x_ready, mul_a, mul_b, res_valid, res_bin, res_s1, res_s2
    );

    modport slave (
        output x_i, x_valid, mul_c, res_ready,
        input  x_ready, mul_a, mul_b, res_valid, res_bin, res_s1, res_s2
    );
endinterface

// File: rtl/goertzel_sched.sv
// Time-multiplexed Goertzel recursion over NF bins with one shared external multiplier.
// The recursion runs for NS samples, then streams and clears the per-bin (s1, s2) state.
module goertzel_sched #(
    parameter int NF = 11,
    parameter int NS = 256
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             coef_valid,
    input  logic [NF*64-1:0] alpha_i,
    goertzel_sched_if.master bus,
    output logic             busy,
    output logic             done
);
    localparam int BW = $clog2(NF);
    localparam int CW = $clog2(NS);
    localparam logic [BW-1:0] BIN_LAST = BW'(NF - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(NS - 1);

    typedef enum logic [2:0] {IDLE, WCOEF, WSAMP, MUL, ACC, OUT, DONE} state_t;

    state_t             state_q, state_d;
    logic [BW-1:0]      bin_q, bin_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic signed [63:0] x_q, x_d;
    logic signed [63:0] mul_a_q, mul_a_d;
    logic signed [63:0] mul_b_q, mul_b_d;
    logic signed [63:0] s1_q [NF];
    logic signed [63:0] s1_d [NF];
    logic signed [63:0] s2_q [NF];
    logic signed [63:0] s2_d [NF];
    logic signed [63:0] alpha_w [NF];
    logic signed [63:0] s_acc;

    // s = x + alpha*s1 - s2, wrapping modulo 2^64
    function automatic logic signed [63:0] rec_step(input logic signed [63:0] x,
                                                    input logic signed [63:0] prod,
                                                    input logic signed [63:0] s2);
        return x + prod - s2;
    endfunction

    for (genvar k = 0; k < NF; k++) begin : g_alpha
        assign alpha_w[k] = alpha_i[k*64 +: 64];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            bin_q   <= '0;
            cnt_q   <= '0;
            x_q     <= '0;
            mul_a_q <= '0;
            mul_b_q <= '0;
            for (int k = 0; k < NF; k++) begin
                s1_q[k] <= '0;
                s2_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = WCOEF;
            WCOEF:   if (coef_valid) state_d = WSAMP;
            WSAMP:   if (bus.x_valid) state_d = MUL;
            MUL:     state_d = ACC;
            ACC: begin
                if (bin_q != BIN_LAST)      state_d = MUL;
                else if (cnt_q == CNT_LAST) state_d = OUT;
                else                        state_d = WSAMP;
            end
            OUT:     if (bus.res_ready && bin_q == BIN_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // mul_c is combinational from the registered operands, so it is valid during ACC
    always_comb begin
        bin_d   = bin_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        s_acc   = rec_step(x_q, bus.mul_c, s2_q[bin_q]);
        case (state_q)
            WSAMP: begin
                if (bus.x_valid) begin
                    x_d   = bus.x_i;
                    bin_d = '0;
                end
            end
            MUL: begin
                mul_a_d = alpha_w[bin_q];
                mul_b_d = s1_q[bin_q];
            end
            ACC: begin
                s2_d[bin_q] = s1_q[bin_q];
                s1_d[bin_q] = s_acc;
                if (bin_q != BIN_LAST) begin
                    bin_d = bin_q + 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    bin_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            OUT: begin
                if (bus.res_ready) begin
                    s1_d[bin_q] = '0;
                    s2_d[bin_q] = '0;
                    if (bin_q != BIN_LAST) bin_d = bin_q + 1'b1;
                end
            end
            DONE:    bin_d = '0;
            default: ;
        endcase
    end

    always_comb begin
        busy          = (state_q != IDLE);
        done          = (state_q == DONE);
        bus.x_ready   = (state_q == WSAMP);
        bus.mul_a     = mul_a_q;
        bus.mul_b     = mul_b_q;
        bus.res_valid = (state_q == OUT);
        bus.res_bin   = '0;
        bus.res_s1    = '0;
        bus.res_s2    = '0;
        if (state_q == OUT) begin
            bus.res_bin = bin_q;
            bus.res_s1  = s1_q[bin_q];
            bus.res_s2  = s2_q[bin_q];
        end
    end
endmodule

// File: tb/tb_goertzel_sched.sv
// Directed bench for goertzel_sched with NF=2, NS=3 and a 32.32 multiplier model.
module tb_goertzel_sched;
    localparam int NF = 2;
    localparam int NS = 3;
    localparam logic [63:0] ONE   = 64'h00000001_00000000;
    localparam logic [63:0] TWO   = 64'h00000002_00000000;
    localparam logic [63:0] THREE = 64'h00000003_00000000;
    localparam logic [63:0] SIX   = 64'h00000006_00000000;
    localparam logic [63:0] ZERO  = 64'h0;

    logic             clk;
    logic             rstn;
    logic             start;
    logic             coef_valid;
    logic [NF*64-1:0] alpha_i;
    logic             busy;
    logic             done;
    int               total;
    int               bad;

    goertzel_sched_if #(.NF(NF)) bus ();

    goertzel_sched #(.NF(NF), .NS(NS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .coef_valid(coef_valid),
        .alpha_i(alpha_i), .bus(bus), .busy(busy), .done(done)
    );

    // external signed 32.32 multiplier
    logic signed [127:0] pa, pb, prod;
    assign pa = bus.mul_a;
    assign pb = bus.mul_b;
    assign prod = pa * pb;
    assign bus.mul_c = prod[95:32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"},    64'(busy), 64'd0);
        chk({tag, "_x_ready"}, 64'(bus.x_ready), 64'd0);
        chk({tag, "_mul_a"},   bus.mul_a, ZERO);
        chk({tag, "_mul_b"},   bus.mul_b, ZERO);
        chk({tag, "_res_vld"}, 64'(bus.res_valid), 64'd0);
        chk({tag, "_res_bin"}, 64'(bus.res_bin), 64'd0);
        chk({tag, "_res_s1"},  bus.res_s1, ZERO);
        chk({tag, "_res_s2"},  bus.res_s2, ZERO);
        chk({tag, "_done"},    64'(done), 64'd0);
    endtask

    // Called in WSAMP with x_valid high; walks accept, MUL/ACC of both bins.
    task automatic feed(input logic [63:0] a, input logic [63:0] eb0,
                        input logic [63:0] eb1, input bit last);
        chk("x_ready_wsamp", 64'(bus.x_ready), 64'd1);
        step();
        chk("x_ready_mul", 64'(bus.x_ready), 64'd0);
        step();
        chk("mul_a_bin0", bus.mul_a, a);
        chk("mul_b_bin0", bus.mul_b, eb0);
        step();
        step();
        chk("mul_a_bin1", bus.mul_a, a);
        chk("mul_b_bin1", bus.mul_b, eb1);
        step();
        if (!last) chk("x_ready_after_5", 64'(bus.x_ready), 64'd1);
        else       chk("res_valid_out", 64'(bus.res_valid), 64'd1);
    endtask

    task automatic start_block(input logic [63:0] a);
        alpha_i    = {a, a};
        coef_valid = 1'b1;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk("busy_wcoef", 64'(busy), 64'd1);
        step();
        x_valid_set();
    endtask

    task automatic x_valid_set();
        bus.x_valid = 1'b1;
        bus.x_i     = ONE;
    endtask

    task automatic drain(input logic [63:0] es1, input logic [63:0] es2, input int stall);
        bus.res_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            start = (i == 0);
            chk("stall_valid", 64'(bus.res_valid), 64'd1);
            chk("stall_bin", 64'(bus.res_bin), 64'd0);
            chk("stall_s1", bus.res_s1, es1);
            chk("stall_s2", bus.res_s2, es2);
            step();
        end
        start = 1'b0;
        bus.res_ready = 1'b1;
        chk("beat0_valid", 64'(bus.res_valid), 64'd1);
        chk("beat0_bin", 64'(bus.res_bin), 64'd0);
        chk("beat0_s1", bus.res_s1, es1);
        chk("beat0_s2", bus.res_s2, es2);
        chk("out_x_ready", 64'(bus.x_ready), 64'd0);
        step();
        chk("beat1_valid", 64'(bus.res_valid), 64'd1);
        chk("beat1_bin", 64'(bus.res_bin), 64'd1);
        chk("beat1_s1", bus.res_s1, es1);
        chk("beat1_s2", bus.res_s2, es2);
        step();
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_res_valid", 64'(bus.res_valid), 64'd0);
        bus.x_valid = 1'b0;
        step();
        chk("done_low", 64'(done), 64'd0);
        chk("busy_low", 64'(busy), 64'd0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rstn = 1'b0;
        start = 1'b0;
        coef_valid = 1'b0;
        alpha_i = '0;
        bus.x_i = '0;
        bus.x_valid = 1'b0;
        bus.res_ready = 1'b0;

        step();
        step();
        chk_idle_outputs("reset");
        rstn = 1'b1;
        repeat (10) step();
        chk_idle_outputs("idle");

        // coefficient gating, then alpha=2.0 block with res_ready high
        alpha_i = {TWO, TWO};
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("gate_busy", 64'(busy), 64'd1);
        chk("gate_x_ready", 64'(bus.x_ready), 64'd0);
        coef_valid = 1'b1;
        step();
        chk("gate_open", 64'(bus.x_ready), 64'd1);
        x_valid_set();
        feed(TWO, ZERO, ZERO, 1'b0);
        feed(TWO, ONE, ONE, 1'b0);
        feed(TWO, THREE, THREE, 1'b1);
        drain(SIX, THREE, 0);

        // second block from cleared state with 4-cycle result stall and a stray start
        start_block(TWO);
        feed(TWO, ZERO, ZERO, 1'b0);
        feed(TWO, ONE, ONE, 1'b0);
        feed(TWO, THREE, THREE, 1'b1);
        drain(SIX, THREE, 4);

        // alpha = 0
        start_block(ZERO);
        feed(ZERO, ZERO, ZERO, 1'b0);
        feed(ZERO, ONE, ONE, 1'b0);
        feed(ZERO, ONE, ONE, 1'b1);
        drain(ZERO, ONE, 0);

        // reset during ACC of the second sample
        start_block(TWO);
        feed(TWO, ZERO, ZERO, 1'b0);
        step();
        step();
        rstn = 1'b0;
        step();
        chk_idle_outputs("midreset");
        rstn = 1'b1;
        bus.x_valid = 1'b0;
        step();
        start_block(TWO);
        feed(TWO, ZERO, ZERO, 1'b0);
        feed(TWO, ONE, ONE, 1'b0);
        feed(TWO, THREE, THREE, 1'b1);
        drain(SIX, THREE, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
